// File: rtl/t2mi_cfg_sequencer_pkg.sv
// rtl/t2mi_cfg_sequencer_pkg.sv - shared address map, FSM states and config record for the T2-MI config sequencer
package t2mi_cfg_sequencer_pkg;

  localparam logic [7:0] CFG_ADDR_SFLEN0      = 8'h01;
  localparam logic [7:0] CFG_ADDR_SFLEN1      = 8'h02;
  localparam logic [7:0] CFG_ADDR_SFLEN2      = 8'h03;
  localparam logic [7:0] CFG_ADDR_SFLEN3      = 8'h04;
  localparam logic [7:0] CFG_ADDR_T2MI_PID_LO = 8'h05;
  localparam logic [7:0] CFG_ADDR_T2MI_PID_HI = 8'h06;
  localparam logic [7:0] CFG_ADDR_PMT_PID_LO  = 8'h07;
  localparam logic [7:0] CFG_ADDR_PMT_PID_HI  = 8'h08;
  localparam logic [7:0] CFG_ADDR_MISC        = 8'h09;
  localparam logic [7:0] CFG_ADDR_COMMIT      = 8'h0A;
  localparam logic [7:0] CFG_ADDR_ABORT       = 8'h0B;

  // PIDs below 0x0020 are MPEG-reserved and 0x1FFF is the null PID
  localparam logic [12:0] PID_RSV_LIMIT = 13'h0020;
  localparam logic [12:0] PID_NULL      = 13'h1FFF;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CHECK    = 2'd1,
    ST_WAIT_BND = 2'd2,
    ST_HOLD     = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic [1:0]  timestamp_type;
    logic [26:0] sframe_len;
    logic [12:0] t2mi_pid;
    logic [2:0]  stream_id;
    logic [12:0] pmt_pid;
  } cfg_t;

  function automatic logic pid_usable(input logic [12:0] pid);
    return (pid >= PID_RSV_LIMIT) && (pid != PID_NULL);
  endfunction

endpackage

// File: rtl/t2mi_cfg_check.sv
// rtl/t2mi_cfg_check.sv - combinational legality check of a staged T2-MI configuration
module t2mi_cfg_check
  import t2mi_cfg_sequencer_pkg::*;
(
  input  logic [26:0] sframe_len,
  input  logic [1:0]  timestamp_type,
  input  logic [12:0] t2mi_pid,
  input  logic [12:0] pmt_pid,
  output logic        valid
);

  always_comb begin
    valid = 1'b1;
    if (sframe_len == 27'd0)       valid = 1'b0;
    if (timestamp_type == 2'd3)    valid = 1'b0;
    if (!pid_usable(t2mi_pid))     valid = 1'b0;
    if (!pid_usable(pmt_pid))      valid = 1'b0;
    if (t2mi_pid == pmt_pid)       valid = 1'b0;
  end

endmodule

// File: rtl/t2mi_cfg_sequencer.sv
// rtl/t2mi_cfg_sequencer.sv - staged, validated, atomic packer config update; CFG_TIMEOUT_EN adds forced apply on boundary timeout
module t2mi_cfg_sequencer
  import t2mi_cfg_sequencer_pkg::*;
#(
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned BND_TIMEOUT    = 2_000_000,
  parameter logic [26:0] DEF_SFRAME_LEN = 27'd1_000_000,
  parameter logic [12:0] DEF_T2MI_PID   = 13'h1000,
  parameter logic [12:0] DEF_PMT_PID    = 13'h0100
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  SPI_DATA,
  input  logic [7:0]  SPI_ADDRESS,
  input  logic        SPI_ENA,
  input  logic        PKT_BOUNDARY,
  output logic [1:0]  timestamp_type,
  output logic [26:0] sframe_len,
  output logic [12:0] t2mi_pid,
  output logic [2:0]  stream_id,
  output logic [12:0] pmt_pid,
  output logic        INNER_RST,
  output logic        BUSY,
  output logic        CFG_ERR
);

  localparam cfg_t DEF_CFG = '{
    timestamp_type: 2'd0,
    sframe_len:     DEF_SFRAME_LEN,
    t2mi_pid:       DEF_T2MI_PID,
    stream_id:      3'd0,
    pmt_pid:        DEF_PMT_PID
  };
  localparam logic [7:0] HOLD_LAST = 8'(RST_CYCLES - 1);

  seq_state_t state, state_nxt;
  cfg_t       shadow, snap, active;
  logic       cfg_err;
  logic [7:0] hold_cnt;
  logic       snap_valid;
  logic       bnd_timeout;

  wire commit    = SPI_ENA && (SPI_ADDRESS == CFG_ADDR_COMMIT);
  wire abort     = SPI_ENA && (SPI_ADDRESS == CFG_ADDR_ABORT);
  wire hold_done = (hold_cnt >= HOLD_LAST);
  wire apply     = (state == ST_WAIT_BND) && (state_nxt == ST_HOLD);

  t2mi_cfg_check u_check (
    .sframe_len     (snap.sframe_len),
    .timestamp_type (snap.timestamp_type),
    .t2mi_pid       (snap.t2mi_pid),
    .pmt_pid        (snap.pmt_pid),
    .valid          (snap_valid)
  );

  // Shadow accepts writes in every state; the in-flight commit only sees snap
  always_ff @(posedge CLK) begin
    if (RST) begin
      shadow <= DEF_CFG;
    end else if (SPI_ENA) begin
      case (SPI_ADDRESS)
        CFG_ADDR_SFLEN0:      shadow.sframe_len[7:0]   <= SPI_DATA;
        CFG_ADDR_SFLEN1:      shadow.sframe_len[15:8]  <= SPI_DATA;
        CFG_ADDR_SFLEN2:      shadow.sframe_len[23:16] <= SPI_DATA;
        CFG_ADDR_SFLEN3:      shadow.sframe_len[26:24] <= SPI_DATA[2:0];
        CFG_ADDR_T2MI_PID_LO: shadow.t2mi_pid[7:0]     <= SPI_DATA;
        CFG_ADDR_T2MI_PID_HI: shadow.t2mi_pid[12:8]    <= SPI_DATA[4:0];
        CFG_ADDR_PMT_PID_LO:  shadow.pmt_pid[7:0]      <= SPI_DATA;
        CFG_ADDR_PMT_PID_HI:  shadow.pmt_pid[12:8]     <= SPI_DATA[4:0];
        CFG_ADDR_MISC: begin
          shadow.timestamp_type <= SPI_DATA[1:0];
          shadow.stream_id      <= SPI_DATA[4:2];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      snap    <= DEF_CFG;
      active  <= DEF_CFG;
      cfg_err <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && commit) snap <= shadow;
      if (apply) active <= snap;
      if ((state == ST_CHECK) && !abort) cfg_err <= !snap_valid;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || (state != ST_HOLD)) begin
      hold_cnt <= 8'd0;
    end else if (hold_cnt != 8'hFF) begin
      hold_cnt <= hold_cnt + 8'd1;
    end
  end

`ifdef CFG_TIMEOUT_EN
  localparam logic [31:0] WAIT_LAST = 32'(BND_TIMEOUT - 1);
  logic [31:0] wait_cnt;

  always_ff @(posedge CLK) begin
    if (RST || (state != ST_WAIT_BND)) begin
      wait_cnt <= 32'd0;
    end else if (wait_cnt != 32'hFFFF_FFFF) begin
      wait_cnt <= wait_cnt + 32'd1;
    end
  end

  assign bnd_timeout = (wait_cnt >= WAIT_LAST);
`else
  assign bnd_timeout = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (commit) state_nxt = ST_CHECK;
      ST_CHECK: begin
        if (abort || !snap_valid) state_nxt = ST_IDLE;
        else                      state_nxt = ST_WAIT_BND;
      end
      ST_WAIT_BND: begin
        if (abort)                            state_nxt = ST_IDLE;
        else if (PKT_BOUNDARY || bnd_timeout) state_nxt = ST_HOLD;
      end
      ST_HOLD:     if (hold_done) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    BUSY      = (state != ST_IDLE);
    INNER_RST = (state == ST_HOLD);
  end

  assign timestamp_type = active.timestamp_type;
  assign sframe_len     = active.sframe_len;
  assign t2mi_pid       = active.t2mi_pid;
  assign stream_id      = active.stream_id;
  assign pmt_pid        = active.pmt_pid;
  assign CFG_ERR        = cfg_err;

endmodule

// File: tb/tb_t2mi_cfg_sequencer.sv
// tb/tb_t2mi_cfg_sequencer.sv - directed and randomized self-checking bench for t2mi_cfg_sequencer
module tb_t2mi_cfg_sequencer;

  logic        CLK = 1'b0;
  logic        RST, SPI_ENA, PKT_BOUNDARY;
  logic [7:0]  SPI_DATA, SPI_ADDRESS;
  logic [1:0]  timestamp_type;
  logic [26:0] sframe_len;
  logic [12:0] t2mi_pid, pmt_pid;
  logic [2:0]  stream_id;
  logic        INNER_RST, BUSY, CFG_ERR;

  int n_cmp = 0;
  int n_bad = 0;

  // Register-level model: raw bytes as written, fields derived on demand
  logic [31:0] m_sf;
  logic [7:0]  m_t2lo, m_t2hi, m_pmlo, m_pmhi, m_misc;
  logic [26:0] s_sf, e_sf;
  logic [12:0] s_t2, s_pm, e_t2, e_pm;
  logic [1:0]  s_ts, e_ts;
  logic [2:0]  s_sid, e_sid;
  logic        s_ok, e_err;

  always #5 CLK = ~CLK;

`ifdef CFG_TIMEOUT_EN
  t2mi_cfg_sequencer #(.BND_TIMEOUT(100)) dut (
`else
  t2mi_cfg_sequencer dut (
`endif
    .CLK(CLK), .RST(RST), .SPI_DATA(SPI_DATA), .SPI_ADDRESS(SPI_ADDRESS),
    .SPI_ENA(SPI_ENA), .PKT_BOUNDARY(PKT_BOUNDARY),
    .timestamp_type(timestamp_type), .sframe_len(sframe_len), .t2mi_pid(t2mi_pid),
    .stream_id(stream_id), .pmt_pid(pmt_pid), .INNER_RST(INNER_RST),
    .BUSY(BUSY), .CFG_ERR(CFG_ERR)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_sflen"}, 32'(sframe_len), 32'(e_sf));
    check({tag, "_t2pid"}, 32'(t2mi_pid), 32'(e_t2));
    check({tag, "_pmpid"}, 32'(pmt_pid), 32'(e_pm));
    check({tag, "_ts"}, 32'(timestamp_type), 32'(e_ts));
    check({tag, "_sid"}, 32'(stream_id), 32'(e_sid));
  endtask

  function automatic logic rules_ok(input logic [26:0] sf, input logic [1:0] ts,
                                    input logic [12:0] a, input logic [12:0] b);
    int ia = int'(a);
    int ib = int'(b);
    if (sf == 0 || ts == 3) return 1'b0;
    if (ia < 32 || ia == 8191 || ib < 32 || ib == 8191) return 1'b0;
    return ia != ib;
  endfunction

  task automatic model_reset();
    m_sf = 32'd1_000_000; m_t2lo = 8'h00; m_t2hi = 8'h10;
    m_pmlo = 8'h00; m_pmhi = 8'h01; m_misc = 8'h00;
    e_sf = 27'd1_000_000; e_t2 = 13'h1000; e_pm = 13'h0100;
    e_ts = 2'd0; e_sid = 3'd0; e_err = 1'b0;
  endtask

  task automatic take_snapshot();
    s_sf = m_sf[26:0];
    s_t2 = {m_t2hi[4:0], m_t2lo};
    s_pm = {m_pmhi[4:0], m_pmlo};
    s_ts = m_misc[1:0];
    s_sid = m_misc[4:2];
    s_ok = rules_ok(s_sf, s_ts, s_t2, s_pm);
  endtask

  task automatic spi_wr(input logic [7:0] a, input logic [7:0] d);
    SPI_ADDRESS = a; SPI_DATA = d; SPI_ENA = 1'b1;
    case (a)
      8'h01: m_sf[7:0] = d;    8'h02: m_sf[15:8] = d;
      8'h03: m_sf[23:16] = d;  8'h04: m_sf[31:24] = d;
      8'h05: m_t2lo = d;       8'h06: m_t2hi = d;
      8'h07: m_pmlo = d;       8'h08: m_pmhi = d;
      8'h09: m_misc = d;
      default: ;
    endcase
    @(negedge CLK);
    SPI_ENA = 1'b0;
  endtask

  task automatic write_cfg(input logic [31:0] sf, input logic [12:0] t2, input logic [12:0] pm,
                           input logic [1:0] ts, input logic [2:0] sid);
    spi_wr(8'h01, sf[7:0]);   spi_wr(8'h02, sf[15:8]);
    spi_wr(8'h03, sf[23:16]); spi_wr(8'h04, sf[31:24]);
    spi_wr(8'h05, t2[7:0]);   spi_wr(8'h06, {3'($urandom), t2[12:8]});
    spi_wr(8'h07, pm[7:0]);   spi_wr(8'h08, {3'($urandom), pm[12:8]});
    spi_wr(8'h09, {3'($urandom), sid, ts});
  endtask

  // mode 0: idle wait, 1: random shadow writes (and ignored commits), 2: rewrite sframe_len
  task automatic do_commit(input int d, input int mode, input int rst_at);
    int cnt;
    take_snapshot();
    spi_wr(8'h0A, 8'($urandom));
    check("commit_busy", 32'(BUSY), 32'd1);
    check("commit_err_hold", 32'(CFG_ERR), 32'(e_err));
    @(negedge CLK);
    e_err = !s_ok;
    check("check_err", 32'(CFG_ERR), 32'(e_err));
    check("check_busy", 32'(BUSY), 32'(s_ok));
    if (!s_ok) begin
      check_outputs("reject");
      return;
    end
    for (int i = 0; i < d; i++) begin
      if (mode == 2 && i < 4) spi_wr(8'(i + 1), 8'($urandom));
      else if (mode == 1 && $urandom_range(0, 1) == 1) spi_wr(8'($urandom_range(1, 10)), 8'($urandom));
      else @(negedge CLK);
    end
    check("wait_busy", 32'(BUSY), 32'd1);
    check("wait_irst", 32'(INNER_RST), 32'd0);
    check_outputs("wait");
    PKT_BOUNDARY = 1'b1;
    @(negedge CLK);
    PKT_BOUNDARY = 1'b0;
    e_sf = s_sf; e_t2 = s_t2; e_pm = s_pm; e_ts = s_ts; e_sid = s_sid;
    check_outputs("apply");
    check("apply_irst", 32'(INNER_RST), 32'd1);
    cnt = 1;
    while (INNER_RST === 1'b1 && cnt < 400) begin
      if (rst_at != 0 && cnt == rst_at) begin
        RST = 1'b1;
        @(negedge CLK);
        model_reset();
        check("rst_irst", 32'(INNER_RST), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_err", 32'(CFG_ERR), 32'd0);
        check_outputs("rst");
        RST = 1'b0;
        return;
      end
      @(negedge CLK);
      if (INNER_RST === 1'b1) cnt++;
    end
    check("hold_len", 32'(cnt), 32'd16);
    check("hold_busy_end", 32'(BUSY), 32'd0);
  endtask

  initial begin
    logic [12:0] corner [6];
    logic [12:0] a, b;
    int cnt;
    corner = '{13'h0000, 13'h001F, 13'h0020, 13'h1FFE, 13'h1FFF, 13'h0555};
    RST = 1'b1; SPI_ENA = 1'b0; SPI_DATA = 8'h00; SPI_ADDRESS = 8'h00; PKT_BOUNDARY = 1'b0;
    model_reset();
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check_outputs("reset");
    check("reset_irst", 32'(INNER_RST), 32'd0);
    check("reset_busy", 32'(BUSY), 32'd0);
    check("reset_err", 32'(CFG_ERR), 32'd0);

    write_cfg(32'd500000, 13'h0200, 13'h0300, 2'd1, 3'd2);
    do_commit(10, 0, 0);

    write_cfg(32'd500000, 13'h0300, 13'h0300, 2'd0, 3'd0);
    do_commit(0, 0, 0);
    write_cfg(32'd123456, 13'h0020, 13'h1FFE, 2'd2, 3'd7);
    do_commit(0, 0, 0);

    // Boundary only during commit and CHECK cycles must not apply; then abort
    write_cfg(32'd77777, 13'h0400, 13'h0401, 2'd0, 3'd5);
    take_snapshot();
    PKT_BOUNDARY = 1'b1;
    spi_wr(8'h0A, 8'h00);
    @(negedge CLK);
    PKT_BOUNDARY = 1'b0;
    repeat (50) @(negedge CLK);
    check("early_bnd_busy", 32'(BUSY), 32'd1);
    check("early_bnd_irst", 32'(INNER_RST), 32'd0);
    spi_wr(8'h0B, 8'h00);
    check("abort_busy", 32'(BUSY), 32'd0);
    check_outputs("abort");

    write_cfg(32'h0ABCDEF, 13'h0123, 13'h0456, 2'd2, 3'd3);
    do_commit(6, 2, 0);

    for (int it = 0; it < 16; it++) begin
      a = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)] : 13'($urandom);
      b = ($urandom_range(0, 3) == 0) ? a : 13'($urandom);
      if ($urandom_range(0, 1) == 1) spi_wr(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(12, 255)), 8'($urandom));
      write_cfg(($urandom_range(0, 7) == 0) ? 32'h0800_0000 : $urandom, a, b,
                2'($urandom), 3'($urandom));
      do_commit($urandom_range(0, 8), $urandom_range(0, 1), 0);
    end

    write_cfg(32'd2000, 13'h0101, 13'h0202, 2'd1, 3'd1);
    do_commit(2, 0, 5);

    write_cfg(32'd3000, 13'h0303, 13'h0404, 2'd2, 3'd4);
    take_snapshot();
    spi_wr(8'h0A, 8'h00);
    @(negedge CLK);
`ifdef CFG_TIMEOUT_EN
    repeat (99) @(negedge CLK);
    check("tmo_before", 32'(INNER_RST), 32'd0);
    @(negedge CLK);
    check("tmo_hold", 32'(INNER_RST), 32'd1);
    e_sf = s_sf; e_t2 = s_t2; e_pm = s_pm; e_ts = s_ts; e_sid = s_sid;
    check_outputs("tmo_apply");
    check("tmo_err", 32'(CFG_ERR), 32'd0);
    cnt = 0;
    while (INNER_RST === 1'b1 && cnt < 400) begin
      @(negedge CLK);
      cnt++;
    end
    check("tmo_release", 32'(INNER_RST), 32'd0);
`else
    repeat (10000) @(negedge CLK);
    check("nobnd_busy", 32'(BUSY), 32'd1);
    check("nobnd_irst", 32'(INNER_RST), 32'd0);
    spi_wr(8'h0B, 8'h00);
    check("nobnd_abort", 32'(BUSY), 32'd0);
    check_outputs("nobnd");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
